// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller:
// stage descriptors, forward-select codes and give_op source codes.
package hazard_pkg;

  localparam int TW  = 2;
  localparam int OPW = 3;

  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  localparam logic [OPW-1:0] GIVE_ALU = 3'd0;
  localparam logic [OPW-1:0] GIVE_DM  = 3'd1;
  localparam logic [OPW-1:0] GIVE_PC8 = 3'd2;
  localparam logic [OPW-1:0] GIVE_Z   = 3'd7;

  // How a shadow stage transforms tnew as a descriptor moves into it.
  localparam int TNEW_KEEP  = 0;
  localparam int TNEW_DEC   = 1;
  localparam int TNEW_CLEAR = 2;

  typedef struct packed {
    logic           wr_en;
    logic [4:0]     addr;
    logic [TW-1:0]  tnew;
    logic [OPW-1:0] give_op;
    logic [4:0]     rs;
    logic [4:0]     rt;
  } stage_desc_t;

  localparam stage_desc_t BUBBLE = '{wr_en: 1'b0, addr: 5'd0, tnew: '0,
                                     give_op: GIVE_Z, rs: 5'd0, rt: 5'd0};

  // $0 is hard-wired, so a write to it never produces a usable value.
  function automatic logic stage_hit(stage_desc_t s, logic [4:0] r);
    return s.wr_en && (s.addr == r) && (r != 5'd0);
  endfunction

  // Younger stage wins outright; a not-yet-ready winner yields no forward.
  function automatic logic [1:0] fwd_sel(stage_desc_t younger, logic [1:0] younger_code,
                                         stage_desc_t older, logic [1:0] older_code,
                                         logic [4:0] r);
    if (stage_hit(younger, r))
      return (younger.tnew == '0) ? younger_code : FWD_NONE;
    if (stage_hit(older, r))
      return (older.tnew == '0) ? older_code : FWD_NONE;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage: resets to a bubble, can be loaded with a bubble,
// and adjusts tnew on the way in according to TNEW_MODE.
module hz_stage_reg
  import hazard_pkg::*;
#(
  parameter int TNEW_MODE = TNEW_KEEP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bubble,
  input  stage_desc_t d,
  output stage_desc_t q
);

  stage_desc_t q_reg;
  stage_desc_t q_next;

  always_comb begin
    q_next = d;
    case (TNEW_MODE)
      TNEW_DEC:   q_next.tnew = (d.tnew == '0) ? '0 : d.tnew - 1'b1;
      TNEW_CLEAR: q_next.tnew = '0;
      default:    ;
    endcase
    if (bubble)
      q_next = BUBBLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q_reg <= BUBBLE;
    else
      q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forward-select generation for a five-stage MIPS pipeline, driven by
// write-back descriptors shadowed through E, M and W.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic [4:0]     rs_D,
  input  logic [4:0]     rt_D,
  input  logic [TW-1:0]  tuse_rs_D,
  input  logic [TW-1:0]  tuse_rt_D,
  input  logic           wr_en_D,
  input  logic [4:0]     wr_addr_D,
  input  logic [TW-1:0]  tnew_D,
  input  logic [OPW-1:0] give_op_D,
  output logic           stall,
  output logic [1:0]     fwd_rs_D,
  output logic [1:0]     fwd_rt_D,
  output logic [1:0]     fwd_rs_E,
  output logic [1:0]     fwd_rt_E,
  output logic [1:0]     fwd_rt_M,
  output logic [OPW-1:0] give_op_E,
  output logic [OPW-1:0] give_op_M,
  output logic [OPW-1:0] give_op_W
);

  // stg[0] is the incoming D descriptor; stg[1..3] are the E, M, W shadows.
  stage_desc_t stg [0:3];
  stage_desc_t e_s;
  stage_desc_t m_s;
  stage_desc_t w_s;

  assign stg[0] = '{wr_en: wr_en_D, addr: wr_addr_D, tnew: tnew_D,
                    give_op: give_op_D, rs: rs_D, rt: rt_D};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      hz_stage_reg #(
        .TNEW_MODE((gi == 0) ? TNEW_KEEP : ((gi == 1) ? TNEW_DEC : TNEW_CLEAR))
      ) u_stage (
        .clk    (clk),
        .reset_n(reset_n),
        .bubble ((gi == 0) ? stall : 1'b0),
        .d      (stg[gi]),
        .q      (stg[gi+1])
      );
    end
  endgenerate

  assign e_s = stg[1];
  assign m_s = stg[2];
  assign w_s = stg[3];

  always_comb begin
    stall = (stage_hit(e_s, rs_D) && (e_s.tnew > tuse_rs_D)) ||
            (stage_hit(e_s, rt_D) && (e_s.tnew > tuse_rt_D)) ||
            (stage_hit(m_s, rs_D) && (m_s.tnew > tuse_rs_D)) ||
            (stage_hit(m_s, rt_D) && (m_s.tnew > tuse_rt_D));

    // An E match blocks M/W even when E is not ready, so stale data is never picked.
    if (stage_hit(e_s, rs_D))
      fwd_rs_D = (e_s.tnew == '0) ? FWD_E : FWD_NONE;
    else
      fwd_rs_D = fwd_sel(m_s, FWD_M, w_s, FWD_W, rs_D);

    if (stage_hit(e_s, rt_D))
      fwd_rt_D = (e_s.tnew == '0) ? FWD_E : FWD_NONE;
    else
      fwd_rt_D = fwd_sel(m_s, FWD_M, w_s, FWD_W, rt_D);

    fwd_rs_E = fwd_sel(m_s, FWD_M, w_s, FWD_W, e_s.rs);
    fwd_rt_E = fwd_sel(m_s, FWD_M, w_s, FWD_W, e_s.rt);
    fwd_rt_M = stage_hit(w_s, m_s.rt) ? FWD_W : FWD_NONE;
  end

  assign give_op_E = e_s.give_op;
  assign give_op_M = m_s.give_op;
  assign give_op_W = w_s.give_op;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer end of the write-back descriptor chain. Each decoder emits three fields per instruction: reg_write, reg_addr and give_op. This block receives them at D and carries them in shadow pipeline registers through E, M and W.
- It compares the shadowed destinations against source registers in D, E and M. From that it produces the stall/bubble control and the forward-select codes for the five-stage MIPS datapath.
- It sits beside the pipeline registers. It owns no datapath.

Parameters:
- TW, 2, width of Tuse/Tnew fields; value 3 in a Tuse field means "never used".
- OPW, 3, width of give_op; value 7 means "no forwardable data".

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- rs_D  in  5  D-stage rs field
- rt_D  in  5  D-stage rt field
- tuse_rs_D  in  TW  cycles until rs is consumed (0 = D, 1 = E, 2 = M, 3 = none)
- tuse_rt_D  in  TW  same, for rt
- wr_en_D  in  1  D instruction writes the GRF
- wr_addr_D  in  5  destination register
- tnew_D  in  TW  cycles after entering E until the result exists (ALU = 1, lw = 2, jal = 0)
- give_op_D  in  OPW  data source at the forwarding point
- stall  out  1  hold PC and the F/D register; insert a bubble into E
- fwd_rs_D  out  2  0 = GRF, 1 = E, 2 = M, 3 = W
- fwd_rt_D  out  2  same encoding as fwd_rs_D
- fwd_rs_E  out  2  0 = pipe reg, 2 = M, 3 = W
- fwd_rt_E  out  2  same encoding as fwd_rs_E
- fwd_rt_M  out  2  0 = pipe reg, 3 = W
- give_op_E  out  OPW  shadow give_op of the E stage
- give_op_M  out  OPW  shadow give_op of the M stage
- give_op_W  out  OPW  shadow give_op of the W stage

Behaviour:
- Shadow state per stage X in {E, M, W}: wr_en, addr, tnew, give_op. E and M also hold rs and rt. The registers update every posedge.
- Advance rules:
  - E <= bubble if stall, else the D fields.
  - M <= E, with tnew = sat_dec(tnew_E), saturating at 0.
  - W <= M, with tnew forced to 0.
- Bubble = all-zero fields with give_op = 7.
- Reset (reset_n low, asynchronous): all shadows become bubbles. Consequently stall = 0, all fwd_* = 0, and all give_op_* = 7 immediately, with no clock needed.
- A reset asserted mid-operation discards all in-flight descriptors. There is no recovery.
- Stage match X(r) = wr_en_X AND addr_X == r AND r != 0. Register $0 never matches, so it is never stalled on or forwarded.
- Stall condition, evaluated combinationally:
  - stall = OR over s in {rs, rt}, X in {E, M} of (X(s_D) AND tnew_X > tuse_s_D).
  - tuse = 3 never stalls.
  - W never stalls.
- D-stage forward for operand s:
  - The youngest matching stage wins, in priority E > M > W.
  - The code is the winning stage, but only if tnew of that stage is 0. Otherwise the code is 0, because stall covers that case.
  - No match gives 0.
- E-stage forward: same rule over {M, W}, using the shadowed rs_E / rt_E.
- M-stage forward: W(rt_M) gives 3, else 0.
- All fwd_* and stall outputs are purely combinational from the shadows plus D inputs, with zero-cycle latency. give_op_X is a direct register output.
- Simultaneous matches in E and M: E wins, even when E is not ready. The stale M value must never be chosen.
- stall and fwd_*_D are computed with the same D inputs. While stall = 1, the fwd_*_D values are don't-care.

Decomposition:
- Shared package hazard_pkg holds:
  - Tuse/Tnew widths and the TUSE_NONE constant
  - FWD_NONE / FWD_E / FWD_M / FWD_W codes
  - GIVE_ALU = 0, GIVE_DM = 1, GIVE_PC8 = 2, GIVE_Z = 7
  - the stage-descriptor struct
- One sub-module, hz_stage_reg: a single shadow stage with asynchronous-reset-to-bubble, a bubble-insert input and a saturating tnew decrement. It is instantiated three times.

Test Plan:
- Reset mid-stream: drive lw $8 into D, then pull reset_n low between edges. Expect stall = 0, fwd all 0 and give_op_E/M/W = 7 before the next clk edge.
- Load-use hazard: lw $8 (tnew 2), then add with rs = $8 (tuse 1).
  - Expect stall = 1 for exactly 1 cycle and give_op_E = 7 next cycle.
  - Then fwd_rs_E = 3 with give_op_W = 1.
- Branch after ALU: add $9, then beq with rs = $9 (tuse 0).
  - Expect 1 stall cycle.
  - Then fwd_rs_D = 2 with give_op_M = 0.
- jal, then jr $31 in the next slot: tnew 0 in E, so expect stall = 0, fwd_rs_D = 1, give_op_E = 2.
- Priority: ori $5 in M (tnew 0) and lw $5 in E (tnew 2), with D add rs = $5. Expect stall = 1; M must not be selected.
- $0 and sw cases:
  - add $0 followed by add rs = $0: expect stall = 0 and fwd_rs_D = 0.
  - lw $4, then sw rt = $4 (tuse 2): expect no stall, then fwd_rt_M = 3.
